// File: rtl/set_ctrl_if.sv
// -----------------------------------------------------------------------------
// set_ctrl_if
// Purpose : Bundles the job handshake, the datapath point bus and the result
//           signals of the SET engine sequencer into one interface.
// Signals : en_i        job request (driven by the requester)
//           hit_i       datapath hit result for the point under test
//           buffer_en_o load strobe to the input buffer
//           clear_o     clear strobe to the input buffer
//           point_x_o   grid x of the point under test
//           point_y_o   grid y of the point under test
//           point_vld_o point_x_o/point_y_o carry a live point
//           busy_o      job in progress
//           valid_o     one-cycle pulse, candidate_o is final
//           candidate_o hit count of the last job
// Modports: slave  - the sequencer (set_ctrl)
//           master - the job requester / datapath side
// -----------------------------------------------------------------------------
interface set_ctrl_if #(
  parameter int COORD_W = 4,
  parameter int CNT_W   = 8
);
  logic               en_i;
  logic               hit_i;
  logic               buffer_en_o;
  logic               clear_o;
  logic [COORD_W-1:0] point_x_o;
  logic [COORD_W-1:0] point_y_o;
  logic               point_vld_o;
  logic               busy_o;
  logic               valid_o;
  logic [CNT_W-1:0]   candidate_o;

  modport slave (
    input  en_i, hit_i,
    output buffer_en_o, clear_o, point_x_o, point_y_o, point_vld_o,
           busy_o, valid_o, candidate_o
  );

  modport master (
    output en_i, hit_i,
    input  buffer_en_o, clear_o, point_x_o, point_y_o, point_vld_o,
           busy_o, valid_o, candidate_o
  );
endinterface

// File: rtl/set_ctrl.sv
// -----------------------------------------------------------------------------
// set_ctrl
// Purpose : Sequencer for the SET engine. Takes a job, strobes the input
//           buffer, sweeps every grid point (x inner loop, y outer loop)
//           through the hit datapath, counts hits and reports the candidate
//           count with a one-cycle valid, clearing the buffer in that cycle.
// Ports   : clk_i  clock, rising edge
//           rst_i  asynchronous active-high reset
//           bus    set_ctrl_if.slave (job handshake, point bus, result)
// Options : SET_CTRL_PIPE_HIT_EN - when defined, hit_i belongs to the point
//           issued one cycle earlier (registered datapath); an extra DRAIN
//           cycle collects the last hit before DONE.
// -----------------------------------------------------------------------------
module set_ctrl #(
  parameter int GRID_MIN = 1,
  parameter int GRID_MAX = 8,
  parameter int COORD_W  = 4,
  parameter int CNT_W    = 8
) (
  input logic       clk_i,
  input logic       rst_i,
  set_ctrl_if.slave bus
);

  localparam logic [COORD_W-1:0] C_MIN = COORD_W'(GRID_MIN);
  localparam logic [COORD_W-1:0] C_MAX = COORD_W'(GRID_MAX);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t             state_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               pointVld_q;
  logic               busy_q;
  logic               valid_q;
  logic               clear_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   cand_q;
  logic               hitLive;

  // hitLive marks the cycles in which hit_i belongs to a live point.
`ifdef SET_CTRL_PIPE_HIT_EN
  logic hitVld_q;
  assign hitLive = hitVld_q;
`else
  assign hitLive = pointVld_q;
`endif

  assign cnt_d = (hitLive && bus.hit_i) ? cnt_q + CNT_W'(1) : cnt_q;

  // The load strobe must fire in the same cycle as the request, so it is
  // the one output that is not registered; reset masks it.
  assign bus.buffer_en_o = (state_q == IDLE) && bus.en_i && !rst_i;
  assign bus.clear_o     = clear_q;
  assign bus.point_x_o   = x_q;
  assign bus.point_y_o   = y_q;
  assign bus.point_vld_o = pointVld_q;
  assign bus.busy_o      = busy_q;
  assign bus.valid_o     = valid_q;
  assign bus.candidate_o = cand_q;

  // Job sequencer with registered outputs. cand_q is loaded only on the way
  // into DONE so the previous result stays visible during the next sweep.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      x_q        <= C_MIN;
      y_q        <= C_MIN;
      pointVld_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      clear_q    <= 1'b0;
      cnt_q      <= '0;
      cand_q     <= '0;
`ifdef SET_CTRL_PIPE_HIT_EN
      hitVld_q   <= 1'b0;
`endif
    end else begin
`ifdef SET_CTRL_PIPE_HIT_EN
      hitVld_q <= pointVld_q;
`endif
      case (state_q)
        IDLE: begin
          if (bus.en_i) begin
            cnt_q      <= '0;
            x_q        <= C_MIN;
            y_q        <= C_MIN;
            pointVld_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          cnt_q <= cnt_d;
          if (x_q == C_MAX) begin
            x_q <= C_MIN;
            if (y_q == C_MAX) begin
              // Last point has just been on the bus.
              y_q        <= C_MIN;
              pointVld_q <= 1'b0;
`ifdef SET_CTRL_PIPE_HIT_EN
              state_q    <= DRAIN;
`else
              cand_q     <= cnt_d;
              valid_q    <= 1'b1;
              clear_q    <= 1'b1;
              state_q    <= DONE;
`endif
            end else begin
              y_q <= y_q + COORD_W'(1);
            end
          end else begin
            x_q <= x_q + COORD_W'(1);
          end
        end
        DRAIN: begin
          // Collects the hit of the final point from the registered datapath.
          cnt_q   <= cnt_d;
          cand_q  <= cnt_d;
          valid_q <= 1'b1;
          clear_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          clear_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_set_ctrl
// Purpose : Directed self-checking bench for set_ctrl (default parameters).
//           All outputs are packed into one vector and compared each cycle
//           against values computed from the bench's own cycle index.
// -----------------------------------------------------------------------------
module tb_set_ctrl;

`ifdef SET_CTRL_PIPE_HIT_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif
  // Negedge index (counted from the first negedge after the start edge) at
  // which valid_o is visible.
  localparam int VLD_K = 64 + PIPE;
  localparam int HIT_NONE = -1;
  localparam int HIT_ALL  = -2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] lastCand;

  set_ctrl_if #(.COORD_W(4), .CNT_W(8)) bus ();

  set_ctrl #(.GRID_MIN(1), .GRID_MAX(8), .COORD_W(4), .CNT_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {point_vld, x, y, busy, valid, clear, candidate, buffer_en}
  function automatic logic [20:0] mkVec(input logic vld, input logic [3:0] x,
                                        input logic [3:0] y, input logic busy,
                                        input logic valid, input logic clr,
                                        input logic [7:0] cand, input logic bufEn);
    return {vld, x, y, busy, valid, clr, cand, bufEn};
  endfunction

  task automatic checkOutput(input string tag, input logic [20:0] expVec);
    logic [20:0] obs;
    obs = {bus.point_vld_o, bus.point_x_o, bus.point_y_o, bus.busy_o,
           bus.valid_o, bus.clear_o, bus.candidate_o, bus.buffer_en_o};
    checks++;
    assert (obs === expVec) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expVec);
    end
  endtask

  // Idle cycles with en_i low; hit_i toggled to show it is ignored.
  task automatic applyIdle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.en_i  = 1'b0;
      bus.hit_i = i[0];
      checkOutput($sformatf("%s_idle%0d", tag, i),
                  mkVec(1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, lastCand, 1'b0));
    end
    bus.hit_i = 1'b0;
  endtask

  // Called at a negedge with the DUT in IDLE. Runs one job; returns at the
  // negedge after DONE (or right after an abort reset).
  task automatic applyStimulus(input string tag, input int hitCycle,
                               input logic [7:0] expCnt, input bit holdEn,
                               input int abortAt);
    logic [20:0] e;
    bus.en_i  = 1'b1;
    bus.hit_i = (hitCycle == HIT_ALL);
    #1;
    checkOutput({tag, "_start"},
                mkVec(1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, lastCand, 1'b1));
    @(posedge clk);
    for (int k = 0; k <= VLD_K + 1; k++) begin
      @(negedge clk);
      if (!holdEn) bus.en_i = 1'b0;
      if (k < 64)
        e = mkVec(1'b1, 4'((k % 8) + 1), 4'((k / 8) + 1), 1'b1, 1'b0, 1'b0,
                  lastCand, 1'b0);
      else if (k < VLD_K)
        e = mkVec(1'b0, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0, lastCand, 1'b0);
      else if (k == VLD_K)
        e = mkVec(1'b0, 4'd1, 4'd1, 1'b1, 1'b1, 1'b1, expCnt, 1'b0);
      else
        e = mkVec(1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, expCnt, holdEn);
      checkOutput($sformatf("%s_k%0d", tag, k), e);
      if (k == abortAt) begin
        // Reset while en_i is high: buffer_en_o must still be masked.
        bus.en_i = 1'b1;
        rst = 1'b1;
        #1;
        lastCand = 8'd0;
        checkOutput({tag, "_async_rst"},
                    mkVec(1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0));
        @(negedge clk);
        checkOutput({tag, "_rst_hold"},
                    mkVec(1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0));
        bus.en_i = 1'b0;
        bus.hit_i = 1'b0;
        rst = 1'b0;
        return;
      end
      bus.hit_i = (hitCycle == HIT_ALL) || (hitCycle == k);
    end
    bus.hit_i = 1'b0;
    lastCand = expCnt;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    lastCand = 8'd0;
    rst      = 1'b1;
    bus.en_i  = 1'b0;
    bus.hit_i = 1'b0;

    // Reset values while reset is held, then idle behaviour.
    @(negedge clk);
    checkOutput("reset_held",
                mkVec(1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0));
    rst = 1'b0;
    applyIdle(10, "t1");

    // No hits, all hits (including outside the live window), single hits.
    applyStimulus("nohit",  HIT_NONE,     8'd0,  1'b0, -1);
    applyIdle(2, "a");
    applyStimulus("allhit", HIT_ALL,      8'd64, 1'b0, -1);
    applyIdle(2, "b");
    // Point (3,5) is sweep index 34.
    applyStimulus("hit35",  34 + PIPE,    8'd1,  1'b0, -1);
    applyIdle(2, "c");
    // Last point (8,8) is sweep index 63.
    applyStimulus("hit88",  63 + PIPE,    8'd1,  1'b0, -1);
    applyIdle(2, "d");
    // Hit in the DONE cycle belongs to no point.
    applyStimulus("hitdone", 64 + PIPE,   8'd0,  1'b0, -1);
    applyIdle(2, "e");
    // Hit in the first sweep cycle: counted only for a combinational datapath.
    applyStimulus("hitfirst", 0, (PIPE != 0) ? 8'd0 : 8'd1, 1'b0, -1);
    applyIdle(2, "f");

    // en_i held high across a job: second job starts right after DONE.
    applyStimulus("hold1", HIT_ALL,  8'd64, 1'b1, -1);
    applyStimulus("hold2", HIT_NONE, 8'd0,  1'b0, -1);
    applyIdle(2, "g");

    // Reset at point (4,6) = sweep index 43, then a fresh job.
    applyStimulus("abort", HIT_ALL, 8'd64, 1'b0, 43);
    applyIdle(5, "h");
    applyStimulus("fresh", 34 + PIPE, 8'd1, 1'b0, -1);
    applyIdle(2, "i");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
